// File: rtl/simon_sound.sv
// Speaker driver for the Simon game: a per-lamp square-wave tone while a lamp is lit,
// or a fixed 4-note jingle on rising edges of LOSE/WIN/HS (jingles override lamp tones).
module simon_sound #(
  parameter int CNT_W    = 17,
  parameter int HALF_P0  = 113636,
  parameter int HALF_P1  = 90192,
  parameter int HALF_P2  = 75843,
  parameter int HALF_P3  = 56818,
  parameter int NOTE_LEN = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] lamp,
  input  logic       lamp_ena,
  input  logic       hs,
  input  logic       win,
  input  logic       lose,
  input  logic       mute,
  output logic       speaker,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, TONE, JINGLE} state_t;
  // Encoded in priority order so a plain magnitude compare decides restarts.
  typedef enum logic [1:0] {PAT_NONE, PAT_HS, PAT_WIN, PAT_LOSE} pat_t;

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_LEN - 1);

  state_t           state_reg, state_next;
  pat_t             pat_reg, pat_next;
  pat_t             rise_pat;
  logic [1:0]       note_reg, note_next;
  logic [1:0]       tone_reg, tone_next;
  logic [CNT_W-1:0] note_cnt_reg, note_cnt_next;
  logic [CNT_W-1:0] half_cnt_reg, half_cnt_next;
  logic             spk_reg, spk_next;
  logic             reload;
  logic [2:0]       trig, trig_q_reg, rise;

  assign trig = {lose, win, hs};
  assign rise = trig & ~trig_q_reg;

  function automatic logic [1:0] pat_tone(input pat_t pat, input logic [1:0] note);
    case (pat)
      PAT_LOSE: pat_tone = 2'd3 - note;
      PAT_WIN:  pat_tone = note;
      PAT_HS:   pat_tone = {1'b1, note[0]};
      default:  pat_tone = 2'd0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] half_last(input logic [1:0] tone);
    case (tone)
      2'd0:    half_last = CNT_W'(HALF_P0 - 1);
      2'd1:    half_last = CNT_W'(HALF_P1 - 1);
      2'd2:    half_last = CNT_W'(HALF_P2 - 1);
      default: half_last = CNT_W'(HALF_P3 - 1);
    endcase
  endfunction

  always_comb begin
    rise_pat = PAT_NONE;
    if (rise[2])      rise_pat = PAT_LOSE;
    else if (rise[1]) rise_pat = PAT_WIN;
    else if (rise[0]) rise_pat = PAT_HS;
  end

  // pat_reg is PAT_NONE outside JINGLE, so any rise starts a jingle from IDLE/TONE.
  always_comb begin
    state_next    = state_reg;
    pat_next      = pat_reg;
    note_next     = note_reg;
    note_cnt_next = note_cnt_reg;
    tone_next     = tone_reg;
    reload        = 1'b0;
    if (rise_pat > pat_reg) begin
      state_next    = JINGLE;
      pat_next      = rise_pat;
      note_next     = 2'd0;
      note_cnt_next = '0;
      tone_next     = pat_tone(rise_pat, 2'd0);
      reload        = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (lamp_ena) begin
            state_next = TONE;
            tone_next  = lamp;
          end
        end
        TONE: begin
          if (!lamp_ena) state_next = IDLE;
          else           tone_next  = lamp;
        end
        JINGLE: begin
          if (note_cnt_reg == NOTE_LAST) begin
            note_cnt_next = '0;
            reload        = 1'b1;
            if (note_reg == 2'd3) begin
              state_next = IDLE;
              pat_next   = PAT_NONE;
            end else begin
              note_next = note_reg + 2'd1;
              tone_next = pat_tone(pat_reg, note_reg + 2'd1);
            end
          end else begin
            note_cnt_next = note_cnt_reg + CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Any new tone selection restarts the half-period count but keeps the current level.
  always_comb begin
    half_cnt_next = half_cnt_reg + CNT_W'(1);
    spk_next      = spk_reg;
    if (state_next == IDLE) begin
      half_cnt_next = '0;
      spk_next      = 1'b0;
    end else if (reload || (state_next != state_reg) || (tone_next != tone_reg)) begin
      half_cnt_next = '0;
    end else if (half_cnt_reg == half_last(tone_reg)) begin
      half_cnt_next = '0;
      spk_next      = ~spk_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pat_reg      <= PAT_NONE;
      note_reg     <= 2'd0;
      tone_reg     <= 2'd0;
      note_cnt_reg <= '0;
      half_cnt_reg <= '0;
      spk_reg      <= 1'b0;
      trig_q_reg   <= 3'b000;
    end else begin
      state_reg    <= state_next;
      pat_reg      <= pat_next;
      note_reg     <= note_next;
      tone_reg     <= tone_next;
      note_cnt_reg <= note_cnt_next;
      half_cnt_reg <= half_cnt_next;
      spk_reg      <= spk_next;
      trig_q_reg   <= trig;
    end
  end

  assign speaker = spk_reg & ~mute;
  assign busy    = (state_reg == JINGLE);

endmodule
